// File: rtl/sdpram_pkg.sv
// Shared constants and the byte-enable merge helper for the byte-enabled SDP RAM family.
package sdpram_pkg;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 3;

  // Widest word be_merge handles; callers cast their operands in and the result back out.
  localparam int MERGE_MAX_W  = 1024;
  localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

  function automatic logic [MERGE_MAX_W-1:0] be_merge(
    input logic [MERGE_MAX_W-1:0]  old_word,
    input logic [MERGE_MAX_W-1:0]  new_word,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_MAX_BE; i++) begin
      if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sdpram_core.sv
// Behavioural byte-enabled storage array: narrow write port, wide read-first port
// returning READ_MUL consecutive words one cycle after the address.
module sdpram_core #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_SIZE   = 1024,
  parameter int READ_MUL   = 4,
  localparam int AW_A      = $clog2(RAM_SIZE),
  localparam int RM_W      = $clog2(READ_MUL),
  localparam int AW_B      = AW_A - RM_W,
  localparam int BE_W      = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic [AW_A-1:0]                addr_a,
  input  logic [BE_W-1:0]                we_a,
  input  logic [DATA_WIDTH-1:0]          din_a,
  input  logic [AW_B-1:0]                addr_b,
  output logic [READ_MUL*DATA_WIDTH-1:0] dout_b
);

  logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we_a[i]) mem[addr_a][i*8 +: 8] <= din_a[i*8 +: 8];
    end
  end

  // Non-blocking read alongside the write gives read-first behaviour on a collision.
  always_ff @(posedge clk) begin
    for (int k = 0; k < READ_MUL; k++) begin
      dout_b[k*DATA_WIDTH +: DATA_WIDTH] <= mem[(AW_A'(addr_b) << RM_W) | AW_A'(k)];
    end
  end

endmodule

// File: rtl/sdpram_byteen_fwd.sv
// Byte-enabled simple dual-port RAM wrapper: optional byte-merged same-cycle forwarding,
// 1..3 cycle read latency, valid flag and output hold when idle.
module sdpram_byteen_fwd
  import sdpram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_SIZE   = 1024,
  parameter int READ_MUL   = 4,
  parameter int LATENCY    = 1,
  parameter int FWD_EN     = 1,
  localparam int AW_A      = $clog2(RAM_SIZE),
  localparam int RM_W      = $clog2(READ_MUL),
  localparam int AW_B      = AW_A - RM_W,
  localparam int BE_W      = DATA_WIDTH / 8,
  localparam int OUT_W     = READ_MUL * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW_A-1:0]       addr_a,
  input  logic [BE_W-1:0]       we_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic                  re_b,
  input  logic [AW_B-1:0]       addr_b,
  output logic [OUT_W-1:0]      dout_b,
  output logic                  dout_valid_b
);

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $fatal(1, "sdpram_byteen_fwd: LATENCY must be in 1..3");
  end
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MERGE_MAX_W) begin : g_bad_width
    $fatal(1, "sdpram_byteen_fwd: DATA_WIDTH must be a multiple of 8");
  end
  if (READ_MUL > RAM_SIZE) begin : g_bad_mul
    $fatal(1, "sdpram_byteen_fwd: READ_MUL must not exceed RAM_SIZE");
  end

  logic [BE_W-1:0]  we_gated;
  logic [OUT_W-1:0] core_dout;

  assign we_gated = rst ? '0 : we_a;

`ifdef _FPGA
  xpm_memory_sdpram #(
    .MEMORY_SIZE        (RAM_SIZE * DATA_WIDTH),
    .MEMORY_PRIMITIVE   ("auto"),
    .CLOCKING_MODE      ("common_clock"),
    .ECC_MODE           ("no_ecc"),
    .MEMORY_INIT_FILE   ("none"),
    .USE_MEM_INIT       (0),
    .WAKEUP_TIME        ("disable_sleep"),
    .MESSAGE_CONTROL    (0),
    .WRITE_DATA_WIDTH_A (DATA_WIDTH),
    .BYTE_WRITE_WIDTH_A (8),
    .ADDR_WIDTH_A       (AW_A),
    .READ_DATA_WIDTH_B  (OUT_W),
    .ADDR_WIDTH_B       (AW_B),
    .READ_RESET_VALUE_B ("0"),
    .READ_LATENCY_B     (1),
    .WRITE_MODE_B       ("read_first")
  ) u_mem (
    .sleep          (1'b0),
    .clka           (clk),
    .ena            (1'b1),
    .wea            (we_gated),
    .addra          (addr_a),
    .dina           (din_a),
    .injectsbiterra (1'b0),
    .injectdbiterra (1'b0),
    .clkb           (clk),
    .rstb           (1'b0),
    .enb            (1'b1),
    .regceb         (1'b1),
    .addrb          (addr_b),
    .doutb          (core_dout),
    .sbiterrb       (),
    .dbiterrb       ()
  );
`else
  sdpram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAM_SIZE   (RAM_SIZE),
    .READ_MUL   (READ_MUL)
  ) u_core (
    .clk    (clk),
    .addr_a (addr_a),
    .we_a   (we_gated),
    .din_a  (din_a),
    .addr_b (addr_b),
    .dout_b (core_dout)
  );
`endif

  // Collision detect happens at issue; the write's bytes travel with the read for one cycle.
  logic [AW_A-1:0]       grp_a;
  logic [AW_A-1:0]       sel_a;
  logic                  coll_next;
  logic                  rd_valid_reg;
  logic                  coll_reg;
  logic [AW_A-1:0]       coll_sel_reg;
  logic [BE_W-1:0]       coll_be_reg;
  logic [DATA_WIDTH-1:0] coll_din_reg;

  assign grp_a     = addr_a >> RM_W;
  assign sel_a     = addr_a & AW_A'(READ_MUL - 1);
  assign coll_next = (FWD_EN != 0) && re_b && (|we_a) && (grp_a == AW_A'(addr_b));

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      coll_reg     <= 1'b0;
      coll_sel_reg <= '0;
      coll_be_reg  <= '0;
      coll_din_reg <= '0;
    end else begin
      rd_valid_reg <= re_b;
      coll_reg     <= coll_next;
      coll_sel_reg <= sel_a;
      coll_be_reg  <= we_a;
      coll_din_reg <= din_a;
    end
  end

  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [OUT_W-1:0]      rd_data;

  assign old_word    = core_dout[coll_sel_reg*DATA_WIDTH +: DATA_WIDTH];
  assign merged_word = DATA_WIDTH'(be_merge(MERGE_MAX_W'(old_word), MERGE_MAX_W'(coll_din_reg),
                                            MERGE_MAX_BE'(coll_be_reg)));

  genvar gi;
  for (gi = 0; gi < READ_MUL; gi++) begin : g_word
    assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] =
      (coll_reg && coll_sel_reg == AW_A'(gi)) ? merged_word
                                              : core_dout[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Extra stages only load on a valid beat, so the last one holds its data while idle.
  for (gi = 1; gi < LATENCY; gi++) begin : g_stage
    logic [OUT_W-1:0] data_reg;
    logic             valid_reg;
    logic [OUT_W-1:0] prev_data;
    logic             prev_valid;

    if (gi == 1) begin : g_from_rd
      assign prev_data  = rd_data;
      assign prev_valid = rd_valid_reg;
    end else begin : g_from_stage
      assign prev_data  = g_stage[gi-1].data_reg;
      assign prev_valid = g_stage[gi-1].valid_reg;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_reg  <= '0;
        valid_reg <= 1'b0;
      end else begin
        valid_reg <= prev_valid;
        if (prev_valid) data_reg <= prev_data;
      end
    end
  end

  if (LATENCY == 1) begin : g_out_direct
    // The core re-reads every cycle, so a single-cycle pipe needs its own hold register.
    logic [OUT_W-1:0] hold_reg;

    always_ff @(posedge clk) begin
      if (rst) hold_reg <= '0;
      else if (rd_valid_reg) hold_reg <= rd_data;
    end

    assign dout_b       = rd_valid_reg ? rd_data : hold_reg;
    assign dout_valid_b = rd_valid_reg;
  end else begin : g_out_staged
    assign dout_b       = g_stage[LATENCY-1].data_reg;
    assign dout_valid_b = g_stage[LATENCY-1].valid_reg;
  end

endmodule

// File: tb/tb_sdpram_byteen_fwd.sv
// Directed bench: three instances (LAT1/fwd, LAT2/fwd, LAT3/read-first) share one stimulus stream.
module tb_sdpram_byteen_fwd;

  localparam int DW  = 32;
  localparam int RS  = 64;
  localparam int RM  = 4;
  localparam int AWA = 6;
  localparam int AWB = 4;
  localparam int BEW = 4;
  localparam int OW  = RM * DW;

  logic           clk = 1'b0;
  logic           rst;
  logic [AWA-1:0] addr_a;
  logic [BEW-1:0] we_a;
  logic [DW-1:0]  din_a;
  logic           re_b;
  logic [AWB-1:0] addr_b;
  logic [OW-1:0]  dout1, dout2, dout3;
  logic           v1, v2, v3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sdpram_byteen_fwd #(.DATA_WIDTH(DW), .RAM_SIZE(RS), .READ_MUL(RM), .LATENCY(1), .FWD_EN(1)) u_d1 (
    .clk(clk), .rst(rst), .addr_a(addr_a), .we_a(we_a), .din_a(din_a),
    .re_b(re_b), .addr_b(addr_b), .dout_b(dout1), .dout_valid_b(v1));
  sdpram_byteen_fwd #(.DATA_WIDTH(DW), .RAM_SIZE(RS), .READ_MUL(RM), .LATENCY(2), .FWD_EN(1)) u_d2 (
    .clk(clk), .rst(rst), .addr_a(addr_a), .we_a(we_a), .din_a(din_a),
    .re_b(re_b), .addr_b(addr_b), .dout_b(dout2), .dout_valid_b(v2));
  sdpram_byteen_fwd #(.DATA_WIDTH(DW), .RAM_SIZE(RS), .READ_MUL(RM), .LATENCY(3), .FWD_EN(0)) u_d3 (
    .clk(clk), .rst(rst), .addr_a(addr_a), .we_a(we_a), .din_a(din_a),
    .re_b(re_b), .addr_b(addr_b), .dout_b(dout3), .dout_valid_b(v3));

  typedef struct {
    logic [AWA-1:0] aa;
    logic [BEW-1:0] we;
    logic [DW-1:0]  din;
    logic           re;
    logic [AWB-1:0] ab;
    logic           ev;   // expected valid on the LATENCY=1 instance after this cycle
    int             k;    // word of the group that is checked
    logic [DW-1:0]  ef;   // expected word with forwarding
    logic [DW-1:0]  en;   // expected word read-first
  } vec_t;

  vec_t tbl [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] wsel(input logic [OW-1:0] d, input int k);
    return d[k*DW +: DW];
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we_a = '0; din_a = '0; addr_a = '0; re_b = 1'b0; addr_b = '0;
  endtask

  // One read, then confirm each instance's valid pulse lands on its own latency.
  task automatic check_read(input logic [AWB-1:0] g, input int k,
                            input logic [DW-1:0] ef, input logic [DW-1:0] en, input string nm);
    addr_b = g; re_b = 1'b1; we_a = '0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      re_b = 1'b0;
      chk_v({nm, "_v1"}, v1, t == 1);
      chk_v({nm, "_v2"}, v2, t == 2);
      chk_v({nm, "_v3"}, v3, t == 3);
      if (t == 1) chk({nm, "_d1"}, wsel(dout1, k), ef);
      if (t == 2) chk({nm, "_d2"}, wsel(dout2, k), ef);
      if (t == 3) chk({nm, "_d3"}, wsel(dout3, k), en);
    end
    $display("read group %0d word %0d: d1=%h d2=%h d3=%h", g, k,
             wsel(dout1, k), wsel(dout2, k), wsel(dout3, k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{6'd6,  4'hF, 32'hAABBCCDD, 1'b0, 4'd0, 1'b0, 1, 32'h00000000, 32'h00000000};
    tbl[1]  = '{6'd6,  4'h5, 32'h11223344, 1'b0, 4'd0, 1'b0, 1, 32'h00000000, 32'h00000000};
    tbl[2]  = '{6'd0,  4'h0, 32'h00000000, 1'b1, 4'd1, 1'b1, 2, 32'hAA22CC44, 32'hAA22CC44};
    tbl[3]  = '{6'd0,  4'h0, 32'h00000000, 1'b0, 4'd0, 1'b0, 2, 32'hAA22CC44, 32'hAA22CC44};
    tbl[4]  = '{6'd9,  4'h8, 32'hFFFFFFFF, 1'b1, 4'd2, 1'b1, 1, 32'hFF000000, 32'h00000000};
    tbl[5]  = '{6'd0,  4'h0, 32'h00000000, 1'b0, 4'd0, 1'b0, 1, 32'hFF000000, 32'h00000000};
    tbl[6]  = '{6'd0,  4'h0, 32'h00000000, 1'b1, 4'd2, 1'b1, 1, 32'hFF000000, 32'hFF000000};
    tbl[7]  = '{6'd10, 4'h3, 32'h0000BEEF, 1'b1, 4'd2, 1'b1, 2, 32'h0000BEEF, 32'h00000000};
    tbl[8]  = '{6'd3,  4'h6, 32'hCAFEF00D, 1'b1, 4'd0, 1'b1, 3, 32'h00FEF000, 32'h00000000};
    tbl[9]  = '{6'd3,  4'h1, 32'h00000011, 1'b1, 4'd3, 1'b1, 3, 32'h00000000, 32'h00000000};
    tbl[10] = '{6'd0,  4'h0, 32'h00000000, 1'b1, 4'd0, 1'b1, 3, 32'h00FEF011, 32'h00FEF011};
    tbl[11] = '{6'd1,  4'h0, 32'hFFFFFFFF, 1'b1, 4'd0, 1'b1, 1, 32'h00000000, 32'h00000000};
    tbl[12] = '{6'd0,  4'h0, 32'h00000000, 1'b0, 4'd0, 1'b0, 1, 32'h00000000, 32'h00000000};
    tbl[13] = '{6'd0,  4'h0, 32'h00000000, 1'b0, 4'd0, 1'b0, 1, 32'h00000000, 32'h00000000};

    // Power-on reset state.
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    chk_v("por_v1", v1, 1'b0); chk_v("por_v2", v2, 1'b0); chk_v("por_v3", v3, 1'b0);
    chk_v("por_d1", |dout1, 1'b0); chk_v("por_d2", |dout2, 1'b0); chk_v("por_d3", |dout3, 1'b0);
    $display("reset: v=%b%b%b", v1, v2, v3);
    rst = 1'b0;

    // Clear the words used below so nothing depends on power-up contents.
    for (int a = 0; a < 32; a++) begin
      addr_a = AWA'(a); we_a = 4'hF; din_a = '0;
      tick();
    end
    idle_inputs();

    // Writes during reset are ignored and outputs stay cleared.
    rst = 1'b1; addr_a = 6'd5; we_a = 4'hF; din_a = 32'hFFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_v("rstw_v1", v1, 1'b0); chk_v("rstw_v2", v2, 1'b0); chk_v("rstw_v3", v3, 1'b0);
      chk_v("rstw_d1", |dout1, 1'b0); chk_v("rstw_d3", |dout3, 1'b0);
      $display("reset cycle %0d: v=%b%b%b", c, v1, v2, v3);
    end
    rst = 1'b0;
    idle_inputs();
    check_read(4'd1, 1, 32'h0, 32'h0, "rst_rd");

    // Table: byte writes, collisions, hold; LAT2/LAT3 lag the LAT1 expectations.
    for (int n = 0; n < 14; n++) begin
      addr_a = tbl[n].aa; we_a = tbl[n].we; din_a = tbl[n].din;
      re_b = tbl[n].re; addr_b = tbl[n].ab;
      tick();
      chk_v($sformatf("row%0d_v1", n), v1, tbl[n].ev);
      chk($sformatf("row%0d_d1", n), wsel(dout1, tbl[n].k), tbl[n].ef);
      if (n >= 1) begin
        chk_v($sformatf("row%0d_v2", n), v2, tbl[n-1].ev);
        chk($sformatf("row%0d_d2", n), wsel(dout2, tbl[n-1].k), tbl[n-1].ef);
      end
      if (n >= 2) begin
        chk_v($sformatf("row%0d_v3", n), v3, tbl[n-2].ev);
        chk($sformatf("row%0d_d3", n), wsel(dout3, tbl[n-2].k), tbl[n-2].en);
      end
      $display("row %0d: v=%b%b%b d1=%h", n, v1, v2, v3, wsel(dout1, tbl[n].k));
    end
    idle_inputs();
    tick(); tick(); tick();

    // A write after the read issues never changes that read's data.
    addr_b = 4'd0; re_b = 1'b1;
    tick();
    chk_v("late_v1", v1, 1'b1); chk("late_d1", wsel(dout1, 0), 32'h0);
    re_b = 1'b0; addr_a = 6'd0; we_a = 4'hF; din_a = 32'h12345678;
    tick();
    chk_v("late_v2", v2, 1'b1); chk("late_d2", wsel(dout2, 0), 32'h0);
    chk_v("late_v1_off", v1, 1'b0); chk("late_d1_hold", wsel(dout1, 0), 32'h0);
    we_a = '0;
    tick();
    chk_v("late_v3", v3, 1'b1); chk("late_d3", wsel(dout3, 0), 32'h0);
    $display("late write: d3 word0=%h", wsel(dout3, 0));
    idle_inputs();
    check_read(4'd0, 0, 32'h12345678, 32'h12345678, "reread");

    // Streaming: distinct word 0 per group, eight back-to-back reads, then hold.
    for (int g = 0; g < 8; g++) begin
      addr_a = AWA'(g * 4); we_a = 4'hF; din_a = 32'h100 + DW'(g);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 11; i++) begin
      re_b = (i < 8); addr_b = AWB'(i < 8 ? i : 0);
      tick();
      chk_v($sformatf("strm%0d_v1", i), v1, i < 8);
      chk($sformatf("strm%0d_d1", i), wsel(dout1, 0), 32'h100 + DW'(i < 8 ? i : 7));
      chk_v($sformatf("strm%0d_v2", i), v2, i >= 1 && i <= 8);
      if (i >= 1) chk($sformatf("strm%0d_d2", i), wsel(dout2, 0), 32'h100 + DW'(i - 1 < 8 ? i - 1 : 7));
      chk_v($sformatf("strm%0d_v3", i), v3, i >= 2 && i <= 9);
      if (i >= 2) chk($sformatf("strm%0d_d3", i), wsel(dout3, 0), 32'h100 + DW'(i - 2 < 8 ? i - 2 : 7));
      $display("stream %0d: v=%b%b%b d1=%h d3=%h", i, v1, v2, v3, wsel(dout1, 0), wsel(dout3, 0));
    end
    idle_inputs();

    // Reset while reads are in flight drops them.
    addr_b = 4'd0; re_b = 1'b1;
    tick(); tick();
    re_b = 1'b0; rst = 1'b1;
    tick();
    chk_v("midrst_v3_a", v3, 1'b0); chk_v("midrst_v2_a", v2, 1'b0); chk_v("midrst_v1_a", v1, 1'b0);
    chk_v("midrst_d3", |dout3, 1'b0); chk_v("midrst_d1", |dout1, 1'b0);
    rst = 1'b0;
    tick();
    chk_v("midrst_v3_b", v3, 1'b0); chk_v("midrst_v2_b", v2, 1'b0);
    tick();
    chk_v("midrst_v3_c", v3, 1'b0);
    $display("mid-flight reset: v=%b%b%b", v1, v2, v3);
    check_read(4'd0, 0, 32'h100, 32'h100, "postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
